// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the AXI burst writer: state encoding,
// beat geometry and AW payload packing.
package axi_wr_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 512;
    localparam int unsigned BYTES          = DEF_DATA_WIDTH / 8;
    localparam int unsigned BEAT_SHIFT     = $clog2(BYTES);
    localparam int unsigned PAGE_BYTES     = 4096;

    localparam int unsigned AW_ADDR_W = 32;
    localparam int unsigned AW_LEN_W  = 8;
    localparam int unsigned AW_W      = AW_ADDR_W + AW_LEN_W;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_AW     = 3'd1;
    localparam state_t ST_W      = 3'd2;
    localparam state_t ST_WAIT_B = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    // AXI len field carries beats-1
    function automatic logic [AW_W-1:0] pack_aw(input logic [8:0] len_beats,
                                                input logic [AW_ADDR_W-1:0] addr);
        logic [AW_LEN_W-1:0] len_f;
        len_f = AW_LEN_W'(len_beats - 9'd1);
        return {len_f, addr};
    endfunction

endpackage

// File: rtl/axi_reg_slice.sv
// Single-entry valid/ack register slice; payload is held while valid and not acked.
module axi_reg_slice #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_vld_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ack_o,
    output logic             out_vld_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ack_i
);

    logic             vld_q;
    logic [WIDTH-1:0] data_q;

    assign in_ack_o   = !vld_q || out_ack_i;
    assign out_vld_o  = vld_q;
    assign out_data_o = data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (in_vld_i && in_ack_o) begin
            vld_q  <= 1'b1;
            data_q <= in_data_i;
        end else if (out_ack_i) begin
            vld_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_burst_writer.sv
// Write DMA: splits a (addr, beats) command into 4 KB-safe INCR bursts on AW/W
// and retires them on B. Optional busy-cycle counter under AXI_BURST_WRITER_PERF_EN.
module axi_burst_writer
    import axi_wr_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH  = 512,
    parameter int unsigned MAX_BURST       = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                     ACLK,
    input  logic                                     ARESETN,
    input  logic [31:0]                              cmd_addr,
    input  logic [23:0]                              cmd_beats,
    input  logic                                     cmd_vld,
    output logic                                     cmd_ack,
    input  logic [AXI_DATA_WIDTH-1:0]                s_data,
    input  logic                                     s_vld,
    output logic                                     s_ack,
    output logic [39:0]                              axi_aw_V,
    output logic                                     axi_aw_V_ap_vld,
    input  logic                                     axi_aw_V_ap_ack,
    output logic [AXI_DATA_WIDTH+AXI_DATA_WIDTH/8:0] axi_w_V,
    output logic                                     axi_w_V_ap_vld,
    input  logic                                     axi_w_V_ap_ack,
    input  logic [1:0]                               axi_b_V_bresp_V,
    input  logic                                     axi_b_V_bresp_V_ap_vld,
    output logic                                     axi_b_V_bresp_V_ap_ack,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     err,
    output logic [31:0]                              perf_cycles
);

    localparam int unsigned W_BYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned W_SHIFT = $clog2(W_BYTES);
    localparam int unsigned W_PW    = AXI_DATA_WIDTH + W_BYTES + 1;
    localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING + 1);

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [23:0]        rem_q, rem_d;
    logic [8:0]         beat_cnt_q, beat_cnt_d;
    logic [OUT_W-1:0]   outst_q, outst_d;
    logic [AW_W-1:0]    aw_q;
    logic               busy_q, done_q, err_q, cmd_ack_q;
    logic [8:0]         cur_len;
    logic               cmd_hs, aw_hs, s_hs, b_hs;
    logic               slice_in_ack, w_vld;
    logic [W_PW-1:0]    w_in;

    function automatic logic [8:0] burst_len(input logic [11:0] off, input logic [23:0] rem);
        logic [12:0] room;
        logic [23:0] len;
        room = (13'(PAGE_BYTES) - {1'b0, off}) >> W_SHIFT;
        len  = rem;
        if (len > 24'(MAX_BURST)) len = 24'(MAX_BURST);
        if (len > {11'd0, room})  len = {11'd0, room};
        return 9'(len);
    endfunction

    assign cur_len         = {1'b0, aw_q[AW_W-1:AW_ADDR_W]} + 9'd1;
    assign cmd_ack         = cmd_ack_q;
    assign cmd_hs          = cmd_ack_q && cmd_vld;
    assign axi_aw_V        = aw_q;
    assign axi_aw_V_ap_vld = (state_q == ST_AW) && (outst_q < OUT_W'(MAX_OUTSTANDING));
    assign aw_hs           = axi_aw_V_ap_vld && axi_aw_V_ap_ack;
    assign s_ack           = (state_q == ST_W) && slice_in_ack;
    assign s_hs            = s_ack && s_vld;
    assign axi_b_V_bresp_V_ap_ack = busy_q;
    assign b_hs            = busy_q && axi_b_V_bresp_V_ap_vld;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign w_in            = {(beat_cnt_q == 9'd1), {W_BYTES{1'b1}}, s_data};
    assign axi_w_V_ap_vld  = w_vld;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: if (cmd_hs) begin
                addr_d  = cmd_addr & ~32'(W_BYTES - 1);
                rem_d   = cmd_beats;
                state_d = (cmd_beats == '0) ? ST_DONE : ST_AW;
            end
            ST_AW: if (aw_hs) begin
                addr_d     = addr_q + (32'(cur_len) << W_SHIFT);
                rem_d      = rem_q - 24'(cur_len);
                beat_cnt_d = cur_len;
                state_d    = ST_W;
            end
            // Leaving on slice entry lets the next AW overlap the held last beat
            ST_W: if (s_hs) begin
                beat_cnt_d = beat_cnt_q - 9'd1;
                if (beat_cnt_q == 9'd1) state_d = (rem_q != '0) ? ST_AW : ST_WAIT_B;
            end
            ST_WAIT_B: if (!w_vld && outst_q == '0) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        if (cmd_hs)                                 outst_d = '0;
        else if (aw_hs && !b_hs)                    outst_d = outst_q + OUT_W'(1);
        else if (b_hs && !aw_hs && outst_q != '0)   outst_d = outst_q - OUT_W'(1);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            beat_cnt_q <= '0;
            outst_q    <= '0;
            aw_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cmd_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            beat_cnt_q <= beat_cnt_d;
            outst_q    <= outst_d;
            // Payload tracks addr/rem, which only move on AW ack, so it is stable while pending
            aw_q       <= pack_aw(burst_len(addr_d[11:0], rem_d), addr_d);
            done_q     <= (state_q == ST_DONE);
            cmd_ack_q  <= (state_d == ST_IDLE);
            if (cmd_hs)                       busy_q <= 1'b1;
            else if (state_q == ST_DONE)      busy_q <= 1'b0;
            if (cmd_hs)                       err_q  <= 1'b0;
            else if (b_hs && axi_b_V_bresp_V != 2'd0) err_q <= 1'b1;
        end
    end

    axi_reg_slice #(.WIDTH(W_PW)) u_w_slice (
        .clk_i     (ACLK),
        .rst_ni    (ARESETN),
        .in_vld_i  (s_vld && (state_q == ST_W)),
        .in_data_i (w_in),
        .in_ack_o  (slice_in_ack),
        .out_vld_o (w_vld),
        .out_data_o(axi_w_V),
        .out_ack_i (axi_w_V_ap_ack)
    );

`ifdef AXI_BURST_WRITER_PERF_EN
    logic [31:0] perf_cnt_q, perf_q, perf_inc;

    assign perf_inc    = (perf_cnt_q == '1) ? perf_cnt_q : perf_cnt_q + 32'd1;
    assign perf_cycles = perf_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            perf_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            if (cmd_hs)      perf_cnt_q <= '0;
            else if (busy_q) perf_cnt_q <= perf_inc;
            if (state_q == ST_DONE) perf_q <= perf_inc;
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_axi_burst_writer.sv
// Randomized bench for axi_burst_writer against a burst-splitting reference model.
module tb_axi_burst_writer;

    localparam int unsigned DW  = 512;
    localparam int unsigned NB  = DW / 8;
    localparam int unsigned WPW = DW + NB + 1;

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b1;
    logic [31:0]     cmd_addr = '0;
    logic [23:0]     cmd_beats = '0;
    logic            cmd_vld = 1'b0;
    logic            cmd_ack;
    logic [DW-1:0]   s_data = '0;
    logic            s_vld = 1'b0;
    logic            s_ack;
    logic [39:0]     axi_aw_V;
    logic            axi_aw_V_ap_vld;
    logic            axi_aw_V_ap_ack = 1'b0;
    logic [WPW-1:0]  axi_w_V;
    logic            axi_w_V_ap_vld;
    logic            axi_w_V_ap_ack = 1'b0;
    logic [1:0]      axi_b_V_bresp_V = '0;
    logic            axi_b_V_bresp_V_ap_vld = 1'b0;
    logic            axi_b_V_bresp_V_ap_ack;
    logic            busy, done, err;
    logic [31:0]     perf_cycles;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 ACLK = ~ACLK;

    axi_burst_writer #(
        .AXI_DATA_WIDTH (DW),
        .MAX_BURST      (64),
        .MAX_OUTSTANDING(4)
    ) dut (
        .ACLK                   (ACLK),
        .ARESETN                (ARESETN),
        .cmd_addr               (cmd_addr),
        .cmd_beats              (cmd_beats),
        .cmd_vld                (cmd_vld),
        .cmd_ack                (cmd_ack),
        .s_data                 (s_data),
        .s_vld                  (s_vld),
        .s_ack                  (s_ack),
        .axi_aw_V               (axi_aw_V),
        .axi_aw_V_ap_vld        (axi_aw_V_ap_vld),
        .axi_aw_V_ap_ack        (axi_aw_V_ap_ack),
        .axi_w_V                (axi_w_V),
        .axi_w_V_ap_vld         (axi_w_V_ap_vld),
        .axi_w_V_ap_ack         (axi_w_V_ap_ack),
        .axi_b_V_bresp_V        (axi_b_V_bresp_V),
        .axi_b_V_bresp_V_ap_vld (axi_b_V_bresp_V_ap_vld),
        .axi_b_V_bresp_V_ap_ack (axi_b_V_bresp_V_ap_ack),
        .busy                   (busy),
        .done                   (done),
        .err                    (err),
        .perf_cycles            (perf_cycles)
    );

    task automatic check_eq(input string tag, input logic [WPW-1:0] got, input logic [WPW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_cmd_ack"}, WPW'(cmd_ack), '0);
        check_eq({tag, "_s_ack"},   WPW'(s_ack), '0);
        check_eq({tag, "_aw_vld"},  WPW'(axi_aw_V_ap_vld), '0);
        check_eq({tag, "_w_vld"},   WPW'(axi_w_V_ap_vld), '0);
        check_eq({tag, "_b_ack"},   WPW'(axi_b_V_bresp_V_ap_ack), '0);
        check_eq({tag, "_busy"},    WPW'(busy), '0);
        check_eq({tag, "_done"},    WPW'(done), '0);
        check_eq({tag, "_err"},     WPW'(err), '0);
        check_eq({tag, "_perf"},    WPW'(perf_cycles), '0);
        check_eq({tag, "_aw"},      WPW'(axi_aw_V), '0);
        check_eq({tag, "_w"},       axi_w_V, '0);
    endtask

    // w_mode 0: all acks high, s_vld high; 1: w_ack toggles, aw_ack/s_vld/B random.
    // hold_b: B withheld through that cycle; abort_at: reset asserted at that cycle.
    task automatic run_cmd(input logic [31:0] addr, input int unsigned beats, input int unsigned w_mode,
                           input int unsigned hold_b, input int bad_b, input int unsigned abort_at);
        logic [DW-1:0]  exp_data[$];
        bit             exp_last[$];
        logic [39:0]    exp_aw[$];
        logic [31:0]    a;
        logic [DW-1:0]  d;
        logic [39:0]    aw_prev;
        logic [WPW-1:0] w_prev;
        logic [DW-1:0]  s_prev;
        int unsigned rem, room, len, lim, cyc, first_aw_cyc;
        int unsigned n_sent, n_aw, n_w, n_wlast, n_b;
        bit done_seen, aw_pend, w_pend, s_hs_prev, s_hold, any_vld, exp_err;

        a = addr & ~32'(NB - 1);
        rem = beats;
        while (rem > 0) begin
            room = (4096 - int'(a & 32'hFFF)) / NB;
            len  = rem;
            if (len > 64)   len = 64;
            if (len > room) len = room;
            exp_aw.push_back({8'(len - 1), a});
            for (int unsigned i = 0; i < len; i++) exp_last.push_back(i == len - 1);
            a   = a + 32'(len * NB);
            rem = rem - len;
        end
        for (int unsigned i = 0; i < beats; i++) begin
            for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
            exp_data.push_back(d);
        end
        exp_err = (bad_b >= 0) && (bad_b < int'(exp_aw.size()));

        n_sent = 0; n_aw = 0; n_w = 0; n_wlast = 0; n_b = 0; first_aw_cyc = 0;
        done_seen = 0; aw_pend = 0; w_pend = 0; s_hs_prev = 0; s_hold = 0; any_vld = 0;
        aw_prev = '0; w_prev = '0; s_prev = '0;

        @(negedge ACLK);
        cmd_addr = addr; cmd_beats = 24'(beats); cmd_vld = 1'b1;
        #1;
        lim = 0;
        while (!cmd_ack && lim < 50) begin
            @(negedge ACLK); #1; lim++;
        end
        check_eq("cmd_accept", WPW'(cmd_ack), WPW'(1));
        if (!cmd_ack) begin
            cmd_vld = 1'b0;
            return;
        end

        cyc = 0;
        while (!done_seen && cyc < 4000) begin
            cyc++;
            @(negedge ACLK);
            cmd_vld = 1'b0; cmd_addr = $urandom; cmd_beats = 24'($urandom);
            if (abort_at != 0 && cyc == abort_at) begin
                ARESETN = 1'b0;
                s_vld = 1'b0; axi_b_V_bresp_V_ap_vld = 1'b0;
                #1;
                check_all_zero("rst_mid");
                return;
            end
            if (!s_hold) begin
                if (n_sent < beats && (w_mode == 0 || $urandom_range(0, 2) != 0)) begin
                    s_vld = 1'b1; s_data = exp_data[n_sent];
                end else begin
                    s_vld = 1'b0; s_data = {DW/32{$urandom}};
                end
            end
            axi_w_V_ap_ack  = (w_mode == 0) ? 1'b1 : 1'(cyc % 2);
            axi_aw_V_ap_ack = (w_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (cyc > hold_b && n_wlast > n_b && (w_mode == 0 || $urandom_range(0, 1) == 1)) begin
                axi_b_V_bresp_V_ap_vld = 1'b1;
                axi_b_V_bresp_V = (int'(n_b) == bad_b) ? 2'd2 : 2'd0;
            end else begin
                axi_b_V_bresp_V_ap_vld = 1'b0;
                axi_b_V_bresp_V = 2'($urandom);
            end
            #1;

            if (hold_b != 0 && cyc == hold_b) check_eq("aw_blocked_cnt", WPW'(n_aw), WPW'(4));

            if (aw_pend) begin
                check_eq("aw_vld_hold", WPW'(axi_aw_V_ap_vld), WPW'(1));
                check_eq("aw_stable", WPW'(axi_aw_V), WPW'(aw_prev));
            end
            if (axi_aw_V_ap_vld) begin
                any_vld = 1;
                if (first_aw_cyc == 0) first_aw_cyc = cyc;
            end
            if (axi_aw_V_ap_vld && axi_aw_V_ap_ack) begin
                check_eq("aw_outstanding", WPW'((n_aw - n_b) < 4), WPW'(1));
                if (n_aw < exp_aw.size()) check_eq("aw_payload", WPW'(axi_aw_V), WPW'(exp_aw[n_aw]));
                else                      check_eq("aw_extra", WPW'(n_aw), WPW'(exp_aw.size()));
                n_aw++;
            end
            aw_pend = axi_aw_V_ap_vld && !axi_aw_V_ap_ack;
            aw_prev = axi_aw_V;

            if (s_hs_prev) begin
                check_eq("w_lat_vld", WPW'(axi_w_V_ap_vld), WPW'(1));
                check_eq("w_lat_data", WPW'(axi_w_V[DW-1:0]), WPW'(s_prev));
            end
            if (w_pend) begin
                check_eq("w_vld_hold", WPW'(axi_w_V_ap_vld), WPW'(1));
                check_eq("w_stable", axi_w_V, w_prev);
            end
            if (axi_w_V_ap_vld) any_vld = 1;
            if (axi_w_V_ap_vld && axi_w_V_ap_ack) begin
                if (n_w < beats) begin
                    check_eq("w_beat", axi_w_V, {exp_last[n_w], {NB{1'b1}}, exp_data[n_w]});
                    if (exp_last[n_w]) n_wlast++;
                end else begin
                    check_eq("w_extra", WPW'(n_w), WPW'(beats));
                end
                n_w++;
            end
            w_pend = axi_w_V_ap_vld && !axi_w_V_ap_ack;
            w_prev = axi_w_V;

            s_hs_prev = s_vld && s_ack;
            if (s_hs_prev) begin
                s_prev = s_data;
                n_sent++;
            end
            s_hold = s_vld && !s_ack;

            if (axi_b_V_bresp_V_ap_vld && axi_b_V_bresp_V_ap_ack) n_b++;

            if (done) begin
                done_seen = 1;
                check_eq("done_aw_cnt", WPW'(n_aw), WPW'(exp_aw.size()));
                check_eq("done_w_cnt",  WPW'(n_w), WPW'(beats));
                check_eq("done_b_cnt",  WPW'(n_b), WPW'(exp_aw.size()));
                check_eq("done_err",    WPW'(err), WPW'(exp_err));
                check_eq("done_busy",   WPW'(busy), '0);
                check_eq("done_cmd_ack", WPW'(cmd_ack), WPW'(1));
                if (beats == 0) begin
                    check_eq("zero_done_lat", WPW'(cyc), WPW'(2));
                    check_eq("zero_no_vld", WPW'(any_vld), '0);
                end else begin
                    check_eq("first_aw_lat", WPW'(first_aw_cyc), WPW'(1));
                end
`ifdef AXI_BURST_WRITER_PERF_EN
                check_eq("perf_cycles", WPW'(perf_cycles), WPW'(cyc - 1));
`else
                check_eq("perf_cycles", WPW'(perf_cycles), '0);
`endif
            end
        end
        if (!done_seen) check_eq("done_timeout", '0, WPW'(1));

        @(negedge ACLK);
        s_vld = 1'b0; axi_b_V_bresp_V_ap_vld = 1'b0;
        #1;
        check_eq("done_pulse", WPW'(done), '0);
    endtask

    initial begin
        #1 ARESETN = 1'b0;
        #11;
        check_all_zero("rst_init");
        @(negedge ACLK);
        ARESETN = 1'b1;

        run_cmd(32'h0000_1000, 128, 0, 0, -1, 0);
        run_cmd(32'h0000_1F80, 10, 0, 0, -1, 0);
        run_cmd(32'h0000_1F95, 10, 1, 0, -1, 0);
        run_cmd($urandom, 320, 1, 0, 1, 0);
        run_cmd(32'h1234_5678, 0, 0, 0, -1, 0);
        run_cmd(32'h0000_0000, 320, 0, 400, -1, 0);
        run_cmd(32'hFFFF_FFC0, 3, 1, 0, -1, 0);

        run_cmd(32'h0000_4000, 64, 1, 0, -1, 30);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        #1;
        check_eq("post_rst_cmd_ack", WPW'(cmd_ack), WPW'(1));
        check_eq("post_rst_aw_vld", WPW'(axi_aw_V_ap_vld), '0);
        check_eq("post_rst_w_vld", WPW'(axi_w_V_ap_vld), '0);
        run_cmd(32'h0000_4000, 64, 0, 0, -1, 0);

        for (int t = 0; t < 4; t++)
            run_cmd($urandom, $urandom_range(0, 150), $urandom_range(0, 1), 0,
                    int'($urandom_range(0, 3)) - 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
